apb_master_bridge: RTL and testbench

//  Bridges the CPU data-bus port (busAddr/busWData/busRData/Byte_Enable) to an APB4 peripheral bus.

---
 rtl/apb_master_bridge.sv | 132 +++++++++++++
 tb/tb_apb_master_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// CPU load/store port to APB4 master bridge: decodes the request to one of
// NUM_SLV slaves, runs SETUP/ACCESS, and returns data with a one-cycle strobe.
module apb_master_bridge #(
  parameter int unsigned NUM_SLV = 4,
  parameter logic [15:0] BASE_HI = 16'h1000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic [3:0]              strb,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic [3:0]              PSTRB,
  output logic [NUM_SLV-1:0]      PSEL,
  output logic                    PENABLE,
  input  logic [NUM_SLV*32-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] ABORT_DATA = 32'hDEAD_BEEF;
  localparam logic [CW-1:0] LAST_CNT   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state_q;
  logic          hit_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;

  logic               req_hit_c;
  logic [NUM_SLV-1:0] req_sel_c;
  logic [DW-1:0]      slv_rdata_c;
  logic               slv_ready_c;

  // Address decode of the incoming request
  always_comb begin
    req_hit_c = (addr[31:16] == BASE_HI) && (32'(addr[15:12]) < NUM_SLV);
    req_sel_c = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      req_sel_c[i] = req_hit_c && (addr[15:12] == IW'(i));
    end
  end

  // Only the latched slave's PRDATA/PREADY are observed
  always_comb begin
    slv_rdata_c = '0;
    slv_ready_c = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IW'(i)) begin
        slv_rdata_c = PRDATA[DW*i +: DW];
        slv_ready_c = PREADY[i];
      end
    end
  end

  // Completion is decided combinationally in the ACCESS cycle; PREADY beats timeout
  always_comb begin
    ready = 1'b0;
    err   = 1'b0;
    rdata = '0;
    if (state_q == ACCESS) begin
      if (!hit_q) begin
        ready = 1'b1;
        err   = 1'b1;
      end else if (slv_ready_c) begin
        ready = 1'b1;
        rdata = slv_rdata_c;
      end else if (cnt_q == LAST_CNT) begin
        ready = 1'b1;
        err   = 1'b1;
        rdata = ABORT_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (transfer) begin
            PADDR   <= addr;
            PWRITE  <= write;
            PWDATA  <= wdata;
            PSTRB   <= write ? strb : 4'b0000;
            hit_q   <= req_hit_c;
            idx_q   <= addr[15:12];
            PSEL    <= req_sel_c;
            cnt_q   <= '0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (ready) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, hand sequences for
// back-to-back and mid-transfer reset, and random transfers against a model.
module tb_apb_master_bridge;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              transfer, write;
  logic [31:0]       addr, wdata;
  logic [3:0]        strb;
  logic [31:0]       rdata;
  logic              ready, err;
  logic [31:0]       PADDR, PWDATA;
  logic              PWRITE, PENABLE;
  logic [3:0]        PSTRB;
  logic [NS-1:0]     PSEL;
  logic [NS*32-1:0]  PRDATA;
  logic [NS-1:0]     PREADY;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(.NUM_SLV(NS), .BASE_HI(16'h1000), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .write(write), .addr(addr),
    .wdata(wdata), .strb(strb), .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] slv_data;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_psel;
    logic [3:0]  exp_pstrb;
  } vec_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  psel;
    logic [3:0]  pstrb;
  } exp_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  psel;
    logic        penable_setup;
    logic [3:0]  pstrb;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        penable_done;
    logic [3:0]  psel_after;
    logic        enable_after;
    logic        ready_after;
    logic        clean;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transfer outcome from the address map and the slave's wait count
  function automatic exp_t model(input logic wr, input logic [31:0] a, input logic [3:0] s,
                                 input int waits, input logic [NS*32-1:0] prd);
    exp_t e;
    int   idx;
    bit   hit;
    idx = int'(a[15:12]);
    hit = (a[31:16] == 16'h1000) && (idx < int'(NS));
    e.pstrb = wr ? s : 4'b0000;
    if (!hit) begin
      e.lat = 2; e.err = 1'b1; e.rdata = 32'h0; e.psel = 4'b0000;
    end else begin
      e.psel = 4'b0001 << idx;
      if (waits < int'(TO)) begin
        e.lat = waits + 2; e.err = 1'b0; e.rdata = prd[idx*32 +: 32];
      end else begin
        e.lat = int'(TO) + 1; e.err = 1'b1; e.rdata = 32'hDEAD_BEEF;
      end
    end
    return e;
  endfunction

  // Issue one request from IDLE; the slave answers after 'waits' ACCESS cycles
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input int waits, output obs_t o);
    int acc;
    acc = 0;
    o = '{default: 0};
    o.clean = 1'b1;
    transfer = 1'b1; write = wr; addr = a; wdata = wd; strb = s;
    PREADY = 4'($urandom);
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      if (PENABLE) acc++;
      PREADY = (4'($urandom) & ~PSEL) | ((PENABLE && acc > waits) ? PSEL : 4'b0000);
      #1;
      if (c == 1) begin
        o.psel = PSEL; o.penable_setup = PENABLE; o.pstrb = PSTRB;
        o.paddr = PADDR; o.pwdata = PWDATA; o.pwrite = PWRITE;
      end
      if (ready) begin
        o.lat = c; o.err = err; o.rdata = rdata; o.penable_done = PENABLE;
        break;
      end
      if (err || rdata != 32'h0) o.clean = 1'b0;
    end
    transfer = 1'b0;
    @(posedge clk); #1;
    o.psel_after = PSEL; o.enable_after = PENABLE; o.ready_after = ready;
  endtask

  task automatic verify(input string tag, input obs_t o, input exp_t e,
                        input logic wr, input logic [31:0] a, input logic [31:0] wd);
    check({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
    check({tag, ".err"}, 32'(o.err), 32'(e.err));
    check({tag, ".rdata"}, o.rdata, e.rdata);
    check({tag, ".psel_setup"}, 32'(o.psel), 32'(e.psel));
    check({tag, ".penable_setup"}, 32'(o.penable_setup), 32'h0);
    check({tag, ".pstrb"}, 32'(o.pstrb), 32'(e.pstrb));
    check({tag, ".paddr"}, o.paddr, a);
    check({tag, ".pwdata"}, o.pwdata, wd);
    check({tag, ".pwrite"}, 32'(o.pwrite), 32'(wr));
    check({tag, ".penable_access"}, 32'(o.penable_done), 32'h1);
    check({tag, ".after_idle"}, {o.psel_after, o.enable_after, o.ready_after}, 32'h0);
    check({tag, ".quiet_before_ready"}, 32'(o.clean), 32'h1);
  endtask

  task automatic set_prdata(input logic [31:0] a, input logic [31:0] d);
    PRDATA = {$urandom, $urandom, $urandom, $urandom};
    if (int'(a[15:12]) < int'(NS)) PRDATA[32*int'(a[15:12]) +: 32] = d;
  endtask

  vec_t vecs[7];
  obs_t obs;
  exp_t ex;

  initial begin
    vecs[0] = '{1'b1, 32'h1000_1004, 32'hA5A5_0000, 4'b1100, 0,   32'h0BAD_F00D, 2, 1'b0, 32'h0BAD_F00D, 4'b0010, 4'b1100};
    vecs[1] = '{1'b0, 32'h1000_2010, 32'hFFFF_FFFF, 4'b1111, 3,   32'h1234_5678, 5, 1'b0, 32'h1234_5678, 4'b0100, 4'b0000};
    vecs[2] = '{1'b0, 32'h2000_0000, 32'h1111_2222, 4'b1010, 0,   32'h0,         2, 1'b1, 32'h0,         4'b0000, 4'b0000};
    vecs[3] = '{1'b1, 32'h1000_3000, 32'hCAFE_0001, 4'b0011, 100, 32'h5555_AAAA, 9, 1'b1, 32'hDEAD_BEEF, 4'b1000, 4'b0011};
    vecs[4] = '{1'b1, 32'h1000_4000, 32'h0000_0000, 4'b1111, 0,   32'h0,         2, 1'b1, 32'h0,         4'b0000, 4'b1111};
    vecs[5] = '{1'b0, 32'h1000_0FFC, 32'h0000_0000, 4'b0001, 7,   32'h7777_0007, 9, 1'b0, 32'h7777_0007, 4'b0001, 4'b0000};
    vecs[6] = '{1'b0, 32'h1001_1000, 32'h0000_0000, 4'b0000, 0,   32'h0,         2, 1'b1, 32'h0,         4'b0000, 4'b0000};

    reset = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; strb = '0;
    PRDATA = '0; PREADY = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.bus", {PADDR, PWDATA} == 64'h0 ? 32'h0 : 32'h1, 32'h0);
    check("reset.ctrl", {PSTRB, PSEL, PWRITE, PENABLE, ready, err}, 32'h0);
    check("reset.rdata", rdata, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      exp_t te;
      set_prdata(vecs[i].addr, vecs[i].slv_data);
      te.lat = vecs[i].exp_lat; te.err = vecs[i].exp_err; te.rdata = vecs[i].exp_rdata;
      te.psel = vecs[i].exp_psel; te.pstrb = vecs[i].exp_pstrb;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].waits, obs);
      verify($sformatf("vec%0d", i), obs, te, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Back-to-back stores with transfer held high
    PREADY = 4'hF;
    transfer = 1'b1; write = 1'b1; addr = 32'h1000_0010; wdata = 32'h1111_1111; strb = 4'hF;
    @(posedge clk); #1;
    check("b2b.a_paddr", PADDR, 32'h1000_0010);
    @(posedge clk); #1;
    check("b2b.a_ready", 32'(ready), 32'h1);
    addr = 32'h1000_3020; wdata = 32'h2222_2222; strb = 4'b0101;
    @(posedge clk); #1;
    check("b2b.idle_gap", {PSEL, PENABLE, ready}, 32'h0);
    @(posedge clk); #1;
    check("b2b.b_paddr", PADDR, 32'h1000_3020);
    check("b2b.b_pwdata", PWDATA, 32'h2222_2222);
    check("b2b.b_setup", {PSEL, PENABLE, PSTRB}, {23'h0, 4'b1000, 1'b0, 4'b0101});
    @(posedge clk); #1;
    check("b2b.b_done", {ready, err}, 32'h2);
    transfer = 1'b0;
    @(posedge clk); #1;

    // Reset asserted in the second ACCESS cycle
    PREADY = 4'h0;
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000;
    repeat (3) begin @(posedge clk); #1; end
    check("rst.in_access", {PSEL, PENABLE}, {27'h0, 4'b0100, 1'b1});
    PREADY = 4'hF; reset = 1'b0; transfer = 1'b0;
    #1;
    check("rst.immediate", {PSEL, PENABLE, ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    begin
      logic busy;
      busy = 1'b0;
      repeat (4) begin
        @(posedge clk); #1;
        if (PSEL != '0 || PENABLE || ready) busy = 1'b1;
      end
      check("rst.quiet_after", 32'(busy), 32'h0);
    end

    // Randomized transfers checked against the model
    for (int n = 0; n < 40; n++) begin
      logic        wr;
      logic [31:0] a, wd;
      logic [3:0]  s;
      int          r, w;
      r  = int'($urandom_range(0, 7));
      if (r < 6)       a = {16'h1000, 4'($urandom_range(0, NS - 1)), 12'($urandom)};
      else if (r == 6) a = {16'h1000, 4'($urandom_range(NS, 15)), 12'($urandom)};
      else             a = $urandom;
      wr = 1'($urandom); wd = $urandom; s = 4'($urandom);
      w  = int'($urandom_range(0, 10));
      PRDATA = {$urandom, $urandom, $urandom, $urandom};
      ex = model(wr, a, s, w, PRDATA);
      run_txn(wr, a, wd, s, w, obs);
      verify($sformatf("rnd%0d", n), obs, ex, wr, a, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
